// File: rtl/pc_control_pkg.sv
// Shared constants for the next-PC logic: branch condition codes and ALU flag bit positions.
package pc_control_pkg;

    localparam logic [2:0] CC_NE  = 3'b000;
    localparam logic [2:0] CC_EQ  = 3'b001;
    localparam logic [2:0] CC_GT  = 3'b010;
    localparam logic [2:0] CC_LT  = 3'b011;
    localparam logic [2:0] CC_GE  = 3'b100;
    localparam logic [2:0] CC_LE  = 3'b101;
    localparam logic [2:0] CC_OVF = 3'b110;
    localparam logic [2:0] CC_UNC = 3'b111;

    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_Z = 0;

endpackage

// File: rtl/pc_cond_eval.sv
// Branch condition evaluator: decides whether the condition code holds for the current ALU flags.
module pc_cond_eval
    import pc_control_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [2:0] flag,
    output logic       taken
);

    logic n, v, z;

    assign n = flag[FLAG_N];
    assign v = flag[FLAG_V];
    assign z = flag[FLAG_Z];

    always_comb begin
        taken = 1'b0;
        case (cond)
            CC_NE:   taken = ~z;
            CC_EQ:   taken = z;
            CC_GT:   taken = ~z & ~n;
            CC_LT:   taken = n;
            CC_GE:   taken = z | (~z & ~n);
            CC_LE:   taken = n | z;
            CC_OVF:  taken = v;
            CC_UNC:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_control.sv
// Next-PC selection for the 16-bit core, with a registered copy of the result for debug/trace.
module pc_control
    import pc_control_pkg::*;
#(
    parameter int unsigned PC_W  = 16,
    parameter int unsigned IMM_W = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PC_W-1:0]  pc_in,
    input  logic [IMM_W-1:0] imm,
    input  logic [2:0]       FLAG,
    input  logic [2:0]       C,
    output logic [PC_W-1:0]  pc_out,
    output logic             taken,
    output logic [PC_W-1:0]  pc_q,
    output logic             taken_q
);

    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] offset;
    logic [PC_W-1:0] target;

    // Offset counts 2-byte words: sign-extend, then shift left by one.
    assign offset = {{(PC_W - IMM_W - 1){imm[IMM_W-1]}}, imm, 1'b0};
    assign pc_inc = pc_in + PC_W'(2);
    assign target = pc_inc + offset;

    pc_cond_eval u_cond_eval (
        .cond  (C),
        .flag  (FLAG),
        .taken (taken)
    );

    assign pc_out = taken ? target : pc_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= '0;
            taken_q <= 1'b0;
        end else begin
            pc_q    <= pc_out;
            taken_q <= taken;
        end
    end

endmodule

// File: tb/tb_pc_control.sv
// Self-checking bench for pc_control: directed vector table, C x FLAG sweep, random clocked run, reset.
module tb_pc_control;

    logic        clk;
    logic        rst_n;
    logic [15:0] pc_in;
    logic [8:0]  imm;
    logic [2:0]  FLAG;
    logic [2:0]  C;
    logic [15:0] pc_out;
    logic        taken;
    logic [15:0] pc_q;
    logic        taken_q;

    int n_cmp;
    int n_err;

    pc_control dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .pc_in   (pc_in),
        .imm     (imm),
        .FLAG    (FLAG),
        .C       (C),
        .pc_out  (pc_out),
        .taken   (taken),
        .pc_q    (pc_q),
        .taken_q (taken_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic [8:0]  imm;
        logic [2:0]  flag;
        logic [2:0]  c;
        logic        exp_taken;
        logic [15:0] exp_pc;
    } vec_t;

    vec_t vecs[10];

    // Condition table written directly from the N/V/Z rules.
    function automatic logic ref_taken(input logic [2:0] c, input logic [2:0] f);
        bit n, v, z;
        n = f[2];
        v = f[1];
        z = f[0];
        case (c)
            3'd0:    return !z;
            3'd1:    return z;
            3'd2:    return !z && !n;
            3'd3:    return n;
            3'd4:    return z || (!z && !n);
            3'd5:    return n || z;
            3'd6:    return v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [15:0] ref_pc(input logic [15:0] pc, input logic [8:0] im,
                                           input logic tk);
        int words;
        int next;
        words = (im >= 9'd256) ? int'(im) - 512 : int'(im);
        next  = int'(pc) + 2;
        if (tk) next = next + 2 * words;
        next = ((next % 65536) + 65536) % 65536;
        return next[15:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_comb(input string name);
        logic tk;
        tk = ref_taken(C, FLAG);
        check({name, ".taken"}, {31'd0, taken}, {31'd0, tk});
        check({name, ".pc_out"}, {16'd0, pc_out}, {16'd0, ref_pc(pc_in, imm, tk)});
    endtask

    initial begin
        logic [15:0] exp_pq;
        logic        exp_tq;

        n_cmp = 0;
        n_err = 0;

        vecs[0] = '{16'h0000, 9'h001, 3'b000, 3'b000, 1'b1, 16'h0004};
        vecs[1] = '{16'h0000, 9'h001, 3'b001, 3'b000, 1'b0, 16'h0002};
        vecs[2] = '{16'h0000, 9'h002, 3'b001, 3'b001, 1'b1, 16'h0006};
        vecs[3] = '{16'h0000, 9'h002, 3'b000, 3'b010, 1'b1, 16'h0006};
        vecs[4] = '{16'h0000, 9'h002, 3'b100, 3'b011, 1'b1, 16'h0006};
        vecs[5] = '{16'h0010, 9'h1F8, 3'b000, 3'b111, 1'b1, 16'h0002};
        vecs[6] = '{16'hFFFE, 9'h000, 3'b000, 3'b110, 1'b0, 16'h0000};
        vecs[7] = '{16'h1234, 9'h1FF, 3'b010, 3'b110, 1'b1, 16'h1234};
        vecs[8] = '{16'h0100, 9'h100, 3'b000, 3'b111, 1'b1, 16'hFF02};
        vecs[9] = '{16'h0000, 9'h0FF, 3'b101, 3'b101, 1'b1, 16'h0200};

        rst_n = 1'b0;
        pc_in = '0;
        imm   = '0;
        FLAG  = '0;
        C     = '0;
        #12;
        check("reset.pc_q", {16'd0, pc_q}, 32'h0);
        check("reset.taken_q", {31'd0, taken_q}, 32'h0);

        // Directed table, combinational only.
        for (int i = 0; i < 10; i++) begin
            pc_in = vecs[i].pc;
            imm   = vecs[i].imm;
            FLAG  = vecs[i].flag;
            C     = vecs[i].c;
            #1;
            check($sformatf("vec%0d.taken", i), {31'd0, taken}, {31'd0, vecs[i].exp_taken});
            check($sformatf("vec%0d.pc_out", i), {16'd0, pc_out}, {16'd0, vecs[i].exp_pc});
        end

        // Exhaustive C x FLAG sweep with random PC and offset.
        for (int c = 0; c < 8; c++) begin
            for (int f = 0; f < 8; f++) begin
                C     = 3'(c);
                FLAG  = 3'(f);
                pc_in = 16'($urandom) & 16'hFFFE;
                imm   = 9'($urandom);
                #1;
                check_comb($sformatf("sweep_c%0d_f%0d", c, f));
            end
        end

        @(negedge clk);
        rst_n = 1'b1;

        // Random clocked run: inputs change at negedge, registers checked after posedge.
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            pc_in = 16'($urandom) & 16'hFFFE;
            imm   = 9'($urandom);
            FLAG  = 3'($urandom);
            C     = 3'($urandom);
            if (i % 17 == 0) pc_in = 16'hFFFE;
            #1;
            check_comb($sformatf("rnd%0d", i));
            exp_tq = ref_taken(C, FLAG);
            exp_pq = ref_pc(pc_in, imm, exp_tq);
            @(posedge clk);
            #1;
            check($sformatf("rnd%0d.pc_q", i), {16'd0, pc_q}, {16'd0, exp_pq});
            check($sformatf("rnd%0d.taken_q", i), {31'd0, taken_q}, {31'd0, exp_tq});
        end

        // Load a known nonzero value, then reset asynchronously between edges.
        @(negedge clk);
        pc_in = 16'h1234;
        imm   = 9'h000;
        FLAG  = 3'b000;
        C     = 3'b111;
        @(posedge clk);
        #1;
        check("preload.pc_q", {16'd0, pc_q}, 32'h1236);
        check("preload.taken_q", {31'd0, taken_q}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst.pc_q", {16'd0, pc_q}, 32'h0);
        check("async_rst.taken_q", {31'd0, taken_q}, 32'h0);
        check("rst_comb.pc_out", {16'd0, pc_out}, 32'h1236);
        check("rst_comb.taken", {31'd0, taken}, 32'h1);
        @(posedge clk);
        #1;
        check("rst_hold.pc_q", {16'd0, pc_q}, 32'h0);
        check("rst_hold.taken_q", {31'd0, taken_q}, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        pc_in = 16'h0040;
        imm   = 9'h1FC;
        FLAG  = 3'b001;
        C     = 3'b001;
        @(posedge clk);
        #1;
        check("post_rst.pc_q", {16'd0, pc_q}, 32'h003A);
        check("post_rst.taken_q", {31'd0, taken_q}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
